csr_regfile: RTL and testbench

CSR_REGFILE -- requirements
Module: csr_regfile

---
 rtl/csr_regfile.sv | 154 +++++++++++++++
 tb/tb_csr_regfile.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR register file with 64-bit cycle/instret counters.
// Combinational read with write bypass from WB; writes commit at posedge.
module csr_regfile #(
    parameter logic [31:0] MISA_VAL = 32'h4000_0100,
    parameter logic [31:0] HART_ID  = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_write_en_WB,
    input  logic [11:0] csr_addr_WB,
    input  logic [31:0] csr_data_WB,
    input  logic        retire_WB,
    input  logic [11:0] csr_read_addr_EX,
    output logic [31:0] csr_read_data_EX,
    output logic        csr_read_illegal,
    output logic        csr_write_illegal
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        mst_mie;
    logic        mst_mpie;
    logic [31:0] mie_q;
    logic [29:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [29:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtval_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    logic        wr_ok;
    logic [31:0] wr_view;
    logic [31:0] mstatus_val;

    function automatic logic writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH,
            A_MEPC, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MCYCLEH,
            A_MINSTRET, A_MINSTRETH: writable = 1'b1;
            default:                 writable = 1'b0;
        endcase
    endfunction

    assign wr_ok = csr_write_en_WB && writable(csr_addr_WB);
    assign csr_write_illegal = csr_write_en_WB && !writable(csr_addr_WB);

    // MPP is hardwired to machine mode; only MIE/MPIE hold state
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};

    // Value the addressed CSR will hold after this edge, used for bypass
    always_comb begin
        wr_view = csr_data_WB;
        case (csr_addr_WB)
            A_MSTATUS:      wr_view = (csr_data_WB & 32'h0000_0088) | 32'h0000_1800;
            A_MTVEC, A_MEPC: wr_view = {csr_data_WB[31:2], 2'b00};
            default:        wr_view = csr_data_WB;
        endcase
    end

    // Read mux with same-address write bypass; bypass suppressed in reset
    always_comb begin
        csr_read_data_EX = 32'h0;
        csr_read_illegal = 1'b0;
        case (csr_read_addr_EX)
            A_MSTATUS:                csr_read_data_EX = mstatus_val;
            A_MISA:                   csr_read_data_EX = MISA_VAL;
            A_MIE:                    csr_read_data_EX = mie_q;
            A_MTVEC:                  csr_read_data_EX = {mtvec_q, 2'b00};
            A_MSCRATCH:               csr_read_data_EX = mscratch_q;
            A_MEPC:                   csr_read_data_EX = {mepc_q, 2'b00};
            A_MCAUSE:                 csr_read_data_EX = mcause_q;
            A_MTVAL:                  csr_read_data_EX = mtval_q;
            A_MCYCLE, A_CYCLE:        csr_read_data_EX = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:      csr_read_data_EX = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:    csr_read_data_EX = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH:  csr_read_data_EX = minstret_q[63:32];
            A_MHARTID:                csr_read_data_EX = HART_ID;
            default:                  csr_read_illegal = 1'b1;
        endcase
        if (rst_n && wr_ok && (csr_addr_WB == csr_read_addr_EX))
            csr_read_data_EX = wr_view;
    end

    // Plain CSR storage updated by WB writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_q      <= 32'h0;
            mtvec_q    <= 30'h0;
            mscratch_q <= 32'h0;
            mepc_q     <= 30'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
        end else if (wr_ok) begin
            case (csr_addr_WB)
                A_MSTATUS: begin
                    mst_mie  <= csr_data_WB[3];
                    mst_mpie <= csr_data_WB[7];
                end
                A_MIE:      mie_q      <= csr_data_WB;
                A_MTVEC:    mtvec_q    <= csr_data_WB[31:2];
                A_MSCRATCH: mscratch_q <= csr_data_WB;
                A_MEPC:     mepc_q     <= csr_data_WB[31:2];
                A_MCAUSE:   mcause_q   <= csr_data_WB;
                A_MTVAL:    mtval_q    <= csr_data_WB;
                default:    ;
            endcase
        end
    end

    // Cycle counter: a half-write replaces that half and skips the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mcycle_q <= 64'h0;
        else if (wr_ok && csr_addr_WB == A_MCYCLE)
            mcycle_q <= {mcycle_q[63:32], csr_data_WB};
        else if (wr_ok && csr_addr_WB == A_MCYCLEH)
            mcycle_q <= {csr_data_WB, mcycle_q[31:0]};
        else
            mcycle_q <= mcycle_q + 64'd1;
    end

    // Retired-instruction counter: a half-write drops that cycle's retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            minstret_q <= 64'h0;
        else if (wr_ok && csr_addr_WB == A_MINSTRET)
            minstret_q <= {minstret_q[63:32], csr_data_WB};
        else if (wr_ok && csr_addr_WB == A_MINSTRETH)
            minstret_q <= {csr_data_WB, minstret_q[31:0]};
        else if (retire_WB)
            minstret_q <= minstret_q + 64'd1;
    end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile: vector table through a scoreboard
// queue plus hand sequences for counters and asynchronous reset.
module tb_csr_regfile;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        retire;
    logic [11:0] raddr;
    logic [31:0] rdata;
    logic        rill;
    logic        will;

    int checks;
    int failures;

    typedef struct {
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp_data;
        logic        exp_rill;
        logic        exp_will;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        rill;
        logic        will;
    } exp_t;

    vec_t vecs[18];
    exp_t sb[$];

    csr_regfile dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr_write_en_WB  (we),
        .csr_addr_WB      (waddr),
        .csr_data_WB      (wdata),
        .retire_WB        (retire),
        .csr_read_addr_EX (raddr),
        .csr_read_data_EX (rdata),
        .csr_read_illegal (rill),
        .csr_write_illegal(will)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [11:0] a,
                      input logic [31:0] exp);
        raddr = a;
        #1;
        check(name, rdata, exp);
    endtask

    function automatic vec_t mk(input logic w, input logic [11:0] wa,
                                input logic [31:0] wd, input logic [11:0] ra,
                                input logic [31:0] ed, input logic er,
                                input logic ew);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd; v.raddr = ra;
        v.exp_data = ed; v.exp_rill = er; v.exp_will = ew;
        return v;
    endfunction

    initial begin
        exp_t e;
        checks   = 0;
        failures = 0;

        vecs[0]  = mk(1, 12'h340, 32'hDEADBEEF, 12'h340, 32'hDEADBEEF, 0, 0);
        vecs[1]  = mk(0, 12'h000, 32'h0,        12'h340, 32'hDEADBEEF, 0, 0);
        vecs[2]  = mk(1, 12'h300, 32'hFFFFFFFF, 12'h300, 32'h00001888, 0, 0);
        vecs[3]  = mk(0, 12'h000, 32'h0,        12'h300, 32'h00001888, 0, 0);
        vecs[4]  = mk(1, 12'h305, 32'hFFFFFFFF, 12'h305, 32'hFFFFFFFC, 0, 0);
        vecs[5]  = mk(0, 12'h000, 32'h0,        12'h305, 32'hFFFFFFFC, 0, 0);
        vecs[6]  = mk(1, 12'h341, 32'h12345677, 12'h341, 32'h12345674, 0, 0);
        vecs[7]  = mk(0, 12'h000, 32'h0,        12'h341, 32'h12345674, 0, 0);
        vecs[8]  = mk(1, 12'hC00, 32'h1,        12'h7C0, 32'h0,        1, 1);
        vecs[9]  = mk(1, 12'h7C0, 32'h5,        12'h301, 32'h40000100, 0, 1);
        vecs[10] = mk(0, 12'h000, 32'h0,        12'hF14, 32'h0,        0, 0);
        vecs[11] = mk(1, 12'h342, 32'h8000000B, 12'h343, 32'h0,        0, 0);
        vecs[12] = mk(1, 12'h343, 32'h0000AA55, 12'h342, 32'h8000000B, 0, 0);
        vecs[13] = mk(0, 12'h000, 32'h0,        12'h343, 32'h0000AA55, 0, 0);
        vecs[14] = mk(1, 12'h304, 32'h00000888, 12'h304, 32'h00000888, 0, 0);
        vecs[15] = mk(1, 12'h300, 32'h00000080, 12'h300, 32'h00001880, 0, 0);
        vecs[16] = mk(1, 12'h301, 32'h00000001, 12'h301, 32'h40000100, 0, 1);
        vecs[17] = mk(0, 12'h000, 32'h0,        12'h300, 32'h00001880, 0, 0);

        we = 0; waddr = 0; wdata = 0; retire = 0; raddr = 12'h340;
        rst_n = 1'b0;
        #1;
        check("reset_mscratch", rdata, 32'h0);
        rd("reset_mstatus", 12'h300, 32'h00001800);
        rd("reset_mcycle", 12'hB00, 32'h0);
        check("reset_write_illegal", {31'b0, will}, 32'h0);

        // Counters after release: 10 idle cycles
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rd("mcycle_10", 12'hB00, 32'd10);
        rd("cycle_shadow_10", 12'hC00, 32'd10);
        rd("minstret_0", 12'hB02, 32'd0);
        @(negedge clk);
        retire = 1'b1;
        repeat (3) @(negedge clk);
        retire = 1'b0;
        rd("instret_3", 12'hC02, 32'd3);
        rd("instreth_0", 12'hC82, 32'd0);

        // Table vectors through the scoreboard
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr;
            wdata = vecs[i].wdata; raddr = vecs[i].raddr;
            e.data = vecs[i].exp_data;
            e.rill = vecs[i].exp_rill;
            e.will = vecs[i].exp_will;
            sb.push_back(e);
            #2;
            e = sb.pop_front();
            check($sformatf("vec%0d_data", i), rdata, e.data);
            check($sformatf("vec%0d_rill", i), {31'b0, rill}, {31'b0, e.rill});
            check($sformatf("vec%0d_will", i), {31'b0, will}, {31'b0, e.will});
        end
        check("sb_empty", sb.size(), 32'd0);

        // mcycle carry across halves
        @(negedge clk);
        we = 1; waddr = 12'hB80; wdata = 32'h0;
        @(negedge clk);
        waddr = 12'hB00; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        we = 0; waddr = 0; wdata = 0;
        rd("mcycle_written", 12'hB00, 32'hFFFFFFFF);
        rd("mcycleh_written", 12'hB80, 32'h0);
        @(posedge clk);
        #1;
        rd("mcycle_wrap", 12'hB00, 32'h0);
        rd("mcycleh_carry", 12'hB80, 32'h1);
        rd("cycleh_shadow", 12'hC80, 32'h1);

        // minstret write drops concurrent retire
        @(negedge clk);
        we = 1; waddr = 12'hB02; wdata = 32'h100; retire = 1;
        @(negedge clk);
        we = 0; waddr = 0; wdata = 0; retire = 0;
        rd("minstret_write", 12'hB02, 32'h100);

        // Asynchronous reset with a write pending
        @(negedge clk);
        we = 1; waddr = 12'h340; wdata = 32'h12345678; raddr = 12'h340;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_mscratch", rdata, 32'h0);
        rd("async_mcycle", 12'hB00, 32'h0);
        rd("async_mie", 12'h304, 32'h0);
        rd("async_mtval", 12'h343, 32'h0);
        rd("async_minstret", 12'hB02, 32'h0);
        @(negedge clk);
        we = 0; waddr = 0; wdata = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd("write_lost", 12'h340, 32'h0);
        rd("mcycle_resume", 12'hB00, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
